// File: rtl/tdm_demux_capture.sv
// ----------------------------------------------------------------------------
// tdm_demux_capture
//   Receive end of the channel-select mux path. Demultiplexes a time-division
//   sample stream (one sample per din_valid beat, slot 0 marked by
//   frame_start) into per-channel holding registers. It also tracks a
//   per-channel unread flag and a sticky overrun flag, and pulses frame_done
//   when a complete frame has been captured.
//
//   Build option: define TDM_PARITY_EN to append an even-parity slot (slot
//   NCH) to every frame. That slot is checked against the XOR of the frame's
//   data samples. A match pulses frame_done and a mismatch pulses parity_err.
//
//   Ports:
//     clk, reset    clock; asynchronous active-high reset
//     din           stream sample (WIDTH bits)
//     din_valid     din carries a sample this cycle
//     frame_start   current beat is slot 0
//     rd_ack[n]     consumer acknowledge, clears ch_valid[n]
//     ovr_clr       clears all sticky overrun bits
//     ch_data       channel n at bits [n*WIDTH +: WIDTH]
//     ch_valid[n]   channel n holds unread data
//     overrun[n]    sticky: unread data in channel n was overwritten
//     slot          slot index the next sample will occupy
//     frame_done    1-cycle pulse after the last slot of a frame lands
//     frame_err     1-cycle pulse: frame_start seen while slot != 0
//     parity_err    1-cycle pulse on parity mismatch (0 without TDM_PARITY_EN)
// ----------------------------------------------------------------------------
module tdm_demux_capture #(
    parameter int WIDTH = 1,
    parameter int NCH   = 3,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_start,
    input  logic [NCH-1:0]       rd_ack,
    input  logic                 ovr_clr,
    output logic [NCH*WIDTH-1:0] ch_data,
    output logic [NCH-1:0]       ch_valid,
    output logic [NCH-1:0]       overrun,
    output logic [SELW-1:0]      slot,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 parity_err
);

`ifdef TDM_PARITY_EN
    localparam int FLEN = NCH + 1;
`else
    localparam int FLEN = NCH;
`endif
    localparam logic [SELW-1:0] LAST_SLOT = SELW'(FLEN - 1);
    localparam logic [SELW-1:0] NCH_SLOT  = SELW'(NCH);

    logic [NCH*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [NCH-1:0]       ch_valid_q, ch_valid_d;
    logic [NCH-1:0]       overrun_q, overrun_d;
    logic [SELW-1:0]      slot_q, slot_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;

    logic [SELW-1:0]      eff_slot;
    logic                 capture;
    logic [NCH-1:0]       cap_sel;

`ifdef TDM_PARITY_EN
    logic [WIDTH-1:0]     par_acc_q, par_acc_d;
    logic                 parity_err_q, parity_err_d;
    logic                 par_beat;
    logic                 par_match;
`endif

    always_comb begin
        // frame_start forces this beat into slot 0 regardless of the counter
        eff_slot = frame_start ? '0 : slot_q;
        capture  = din_valid && (eff_slot < NCH_SLOT);

        cap_sel = '0;
        for (int unsigned n = 0; n < NCH; n++) begin
            cap_sel[n] = capture && (eff_slot == SELW'(n));
        end

        ch_data_d  = ch_data_q;
        ch_valid_d = ch_valid_q;
        overrun_d  = overrun_q;
        for (int unsigned n = 0; n < NCH; n++) begin
            if (cap_sel[n]) begin
                ch_data_d[n*WIDTH +: WIDTH] = din;
            end
            // a capture beats a simultaneous acknowledge
            ch_valid_d[n] = cap_sel[n] | (ch_valid_q[n] & ~rd_ack[n]);
            // a new overrun event beats a simultaneous clear
            overrun_d[n]  = (cap_sel[n] & ch_valid_q[n] & ~rd_ack[n]) |
                            (overrun_q[n] & ~ovr_clr);
        end

        if (din_valid) begin
            slot_d = (eff_slot == LAST_SLOT) ? '0 : eff_slot + 1'b1;
        end else if (frame_start) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q;
        end

        frame_err_d = frame_start && (slot_q != '0);

`ifdef TDM_PARITY_EN
        par_beat  = din_valid && (eff_slot == NCH_SLOT);
        par_match = (par_acc_q == din);
        if (capture) begin
            par_acc_d = (eff_slot == '0) ? din : (par_acc_q ^ din);
        end else if (frame_start) begin
            par_acc_d = '0;
        end else begin
            par_acc_d = par_acc_q;
        end
        frame_done_d = par_beat && par_match;
        parity_err_d = par_beat && !par_match;
`else
        frame_done_d = capture && (eff_slot == LAST_SLOT);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            overrun_q    <= '0;
            slot_q       <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef TDM_PARITY_EN
            par_acc_q    <= '0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            overrun_q    <= overrun_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
`ifdef TDM_PARITY_EN
            par_acc_q    <= par_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign overrun    = overrun_q;
    assign slot       = slot_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
`ifdef TDM_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_capture.sv
// ----------------------------------------------------------------------------
// tb_tdm_demux_capture
//   Self-checking bench for tdm_demux_capture (WIDTH=1, NCH=3, SELW=2).
//   It applies a table of directed beats with hand-derived expectations,
//   exercises asynchronous reset and the parity option with directed
//   sequences, and then runs randomized traffic against a behavioural
//   frame model.
// ----------------------------------------------------------------------------
module tb_tdm_demux_capture;

    localparam int W    = 1;
    localparam int NCH  = 3;
    localparam int SELW = 2;
`ifdef TDM_PARITY_EN
    localparam int FLEN = NCH + 1;
`else
    localparam int FLEN = NCH;
`endif

    logic               clk;
    logic               reset;
    logic [W-1:0]       din;
    logic               din_valid;
    logic               frame_start;
    logic [NCH-1:0]     rd_ack;
    logic               ovr_clr;
    logic [NCH*W-1:0]   ch_data;
    logic [NCH-1:0]     ch_valid;
    logic [NCH-1:0]     overrun;
    logic [SELW-1:0]    slot;
    logic               frame_done;
    logic               frame_err;
    logic               parity_err;

    tdm_demux_capture #(.WIDTH(W), .NCH(NCH), .SELW(SELW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .rd_ack     (rd_ack),
        .ovr_clr    (ovr_clr),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .overrun    (overrun),
        .slot       (slot),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural frame model ----------------
    logic [NCH*W-1:0] m_data;
    logic [NCH-1:0]   m_valid;
    logic [NCH-1:0]   m_ovr;
    int               m_slot;
    logic             m_done, m_err, m_perr;
    logic [W-1:0]     m_acc;

    task automatic model_reset();
        m_data = '0; m_valid = '0; m_ovr = '0; m_slot = 0;
        m_done = 1'b0; m_err = 1'b0; m_perr = 1'b0; m_acc = '0;
    endtask

    task automatic model_step(input logic dv, input logic fs, input logic [W-1:0] d,
                              input logic [NCH-1:0] ack, input logic clr);
        int s;
        logic [NCH-1:0] nv, no;
        s      = fs ? 0 : m_slot;
        m_err  = fs && (m_slot != 0);
        m_done = 1'b0;
        m_perr = 1'b0;
        nv     = m_valid & ~ack;
        no     = clr ? '0 : m_ovr;
        if (dv) begin
            if (s < NCH) begin
                if (m_valid[s] && !ack[s]) no[s] = 1'b1;
                nv[s] = 1'b1;
                m_data[s*W +: W] = d;
                m_acc = (s == 0) ? d : (m_acc ^ d);
                if (s == FLEN - 1) m_done = 1'b1;
            end else begin
                if (m_acc == d) m_done = 1'b1;
                else            m_perr = 1'b1;
            end
            m_slot = (s + 1) % FLEN;
        end else if (fs) begin
            m_slot = 0;
        end
        m_valid = nv;
        m_ovr   = no;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".data"},  32'(ch_data),    32'(m_data));
        chk({tag, ".valid"}, 32'(ch_valid),   32'(m_valid));
        chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
        chk({tag, ".slot"},  32'(slot),       32'(m_slot));
        chk({tag, ".done"},  32'(frame_done), 32'(m_done));
        chk({tag, ".err"},   32'(frame_err),  32'(m_err));
        chk({tag, ".perr"},  32'(parity_err), 32'(m_perr));
    endtask

    // one beat: drive inputs, advance model, sample 1 ns after the edge
    task automatic drive(input logic dv, input logic fs, input logic [W-1:0] d,
                         input logic [NCH-1:0] ack, input logic clr);
        din_valid   = dv;
        frame_start = fs;
        din         = d;
        rd_ack      = ack;
        ovr_clr     = clr;
        model_step(dv, fs, d, ack, clr);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic           dv, fs;
        logic [W-1:0]   d;
        logic [NCH-1:0] ack;
        logic           clr;
        logic [NCH-1:0] edata, evalid, eovr;
        logic [SELW-1:0] eslot;
        logic           edone, eerr;
    } vec_t;

    vec_t vecs[26];

    initial begin
        // dv fs d ack clr | data valid ovr slot done err
        vecs[0]  = '{1'b1,1'b1,1'b1,3'b000,1'b0, 3'b001,3'b001,3'b000,2'd1,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,3'b000,1'b0, 3'b001,3'b011,3'b000,2'd2,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b1,3'b000,1'b0, 3'b101,3'b111,3'b000,2'd0,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,3'b000,1'b0, 3'b101,3'b111,3'b000,2'd0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b1,3'b000,1'b0, 3'b101,3'b111,3'b001,2'd1,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,3'b000,1'b0, 3'b111,3'b111,3'b011,2'd2,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,3'b000,1'b0, 3'b011,3'b111,3'b111,2'd0,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,3'b000,1'b0, 3'b010,3'b111,3'b111,2'd1,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,3'b000,1'b0, 3'b010,3'b111,3'b111,2'd2,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,3'b000,1'b0, 3'b110,3'b111,3'b111,2'd0,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,3'b000,1'b1, 3'b110,3'b111,3'b000,2'd0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,3'b111,1'b0, 3'b110,3'b000,3'b000,2'd0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,3'b000,1'b0, 3'b110,3'b001,3'b000,2'd1,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,3'b000,1'b0, 3'b100,3'b011,3'b000,2'd2,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,3'b000,1'b0, 3'b000,3'b111,3'b000,2'd0,1'b1,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,3'b001,1'b0, 3'b001,3'b111,3'b000,2'd1,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b1,3'b010,1'b0, 3'b011,3'b111,3'b000,2'd2,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,1'b0,3'b110,1'b0, 3'b011,3'b101,3'b000,2'd0,1'b1,1'b0};
        vecs[18] = '{1'b1,1'b1,1'b1,3'b111,1'b0, 3'b011,3'b001,3'b000,2'd1,1'b0,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,3'b000,1'b0, 3'b001,3'b011,3'b000,2'd2,1'b0,1'b0};
        vecs[20] = '{1'b1,1'b1,1'b1,3'b000,1'b1, 3'b001,3'b011,3'b001,2'd1,1'b0,1'b1};
        vecs[21] = '{1'b0,1'b0,1'b0,3'b000,1'b0, 3'b001,3'b011,3'b001,2'd1,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b0,1'b1,3'b000,1'b0, 3'b011,3'b011,3'b011,2'd2,1'b0,1'b0};
        vecs[23] = '{1'b0,1'b1,1'b0,3'b000,1'b0, 3'b011,3'b011,3'b011,2'd0,1'b0,1'b1};
        vecs[24] = '{1'b0,1'b0,1'b0,3'b000,1'b1, 3'b011,3'b011,3'b000,2'd0,1'b0,1'b0};
        vecs[25] = '{1'b1,1'b1,1'b0,3'b000,1'b0, 3'b010,3'b011,3'b001,2'd1,1'b0,1'b0};

        din = '0; din_valid = 1'b0; frame_start = 1'b0; rd_ack = '0; ovr_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        #11;
        reset = 1'b0;

        chk("rst.data",  32'(ch_data),    32'd0);
        chk("rst.valid", 32'(ch_valid),   32'd0);
        chk("rst.ovr",   32'(overrun),    32'd0);
        chk("rst.slot",  32'(slot),       32'd0);
        chk("rst.done",  32'(frame_done), 32'd0);
        chk("rst.err",   32'(frame_err),  32'd0);
        chk("rst.perr",  32'(parity_err), 32'd0);

`ifndef TDM_PARITY_EN
        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].dv, vecs[i].fs, vecs[i].d, vecs[i].ack, vecs[i].clr);
            chk($sformatf("vec%0d.data", i),  32'(ch_data),    32'(vecs[i].edata));
            chk($sformatf("vec%0d.valid", i), 32'(ch_valid),   32'(vecs[i].evalid));
            chk($sformatf("vec%0d.ovr", i),   32'(overrun),    32'(vecs[i].eovr));
            chk($sformatf("vec%0d.slot", i),  32'(slot),       32'(vecs[i].eslot));
            chk($sformatf("vec%0d.done", i),  32'(frame_done), 32'(vecs[i].edone));
            chk($sformatf("vec%0d.err", i),   32'(frame_err),  32'(vecs[i].eerr));
            chk($sformatf("vec%0d.perr", i),  32'(parity_err), 32'd0);
        end
`endif

        // asynchronous reset in the middle of a frame
        drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("mid.slot", 32'(slot), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst.data",  32'(ch_data),  32'd0);
        chk("arst.valid", 32'(ch_valid), 32'd0);
        chk("arst.ovr",   32'(overrun),  32'd0);
        chk("arst.slot",  32'(slot),     32'd0);
        #2 reset = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("post.data",  32'(ch_data),  32'b001);
        chk("post.valid", 32'(ch_valid), 32'b001);
        chk("post.slot",  32'(slot),     32'd1);

`ifdef TDM_PARITY_EN
        drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("par.slot", 32'(slot), 32'd3);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        chk("par_ok.done", 32'(frame_done), 32'd1);
        chk("par_ok.perr", 32'(parity_err), 32'd0);
        chk("par_ok.slot", 32'(slot),       32'd0);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("par_bad.done",  32'(frame_done), 32'd0);
        chk("par_bad.perr",  32'(parity_err), 32'd1);
        chk("par_bad.valid", 32'(ch_valid),   32'b111);
        chk("par_bad.data",  32'(ch_data),    32'b101);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic rdv, rfs, rclr;
            logic [W-1:0] rd;
            logic [NCH-1:0] rack;
            rdv  = ($urandom_range(0, 9) < 6);
            rfs  = ($urandom_range(0, 9) < 2);
            rd   = W'($urandom);
            rack = '0;
            for (int n = 0; n < NCH; n++) rack[n] = ($urandom_range(0, 9) < 2);
            rclr = ($urandom_range(0, 9) < 1);
            drive(rdv, rfs, rd, rack, rclr);
            check_model("rnd");
        end

        din_valid = 1'b0; frame_start = 1'b0; rd_ack = '0; ovr_clr = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_capture.md
Name: tdm_demux_capture

Overview:
Receive end of the channel-select mux path. Takes a time-division stream: one sample per din_valid beat, with slot 0 marked by frame_start. Steers each sample into a per-channel holding register, keeps per-channel valid and overrun flags, and pulses frame_done when a full frame has landed. The consumer acknowledges each channel independently through rd_ack.

Parameters:
- WIDTH, 1, bits per sample/channel
- NCH, 3, number of data channels per frame (2..8, need not be a power of 2)
- SELW, 2, width of the slot counter; must satisfy 2**SELW >= NCH+1

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- din  input  WIDTH  stream sample
- din_valid  input  1  din holds a sample this cycle
- frame_start  input  1  current beat is slot 0 (sync, single-cycle)
- rd_ack  input  NCH  per-channel acknowledge; clears ch_valid[n]
- ovr_clr  input  1  clears all sticky overrun bits
- ch_data  output  NCH*WIDTH  channel n at bits [n*WIDTH +: WIDTH]
- ch_valid  output  NCH  channel holds unread data
- overrun  output  NCH  sticky: unread channel data was overwritten
- slot  output  SELW  slot index the next sample will occupy
- frame_done  output  1  1-cycle pulse: last slot of a frame captured
- frame_err  output  1  1-cycle pulse: frame_start arrived with slot != 0
- parity_err  output  1  1-cycle pulse, parity option only; otherwise constant 0

Behaviour:
- Reset (async): slot=0, ch_data=0, ch_valid=0, overrun=0, frame_done=0, frame_err=0, parity_err=0.
- All state is updated on posedge clk. Capture latency is 1 cycle: a sample accepted at edge k is visible on ch_data/ch_valid after edge k.
- Effective slot of a beat: 0 if frame_start=1, else the slot register.
- din_valid=1 with effective slot s < NCH:
  - ch_data[s] <= din; ch_valid[s] <= 1.
  - slot <= s+1, wrapping to 0 after the last slot of the frame.
- Frame length is NCH slots (NCH+1 when TDM_PARITY_EN is defined). The counter wraps explicitly and never takes values >= frame length.
- On capture of the last slot: frame_done=1 for exactly the following cycle.
- frame_start=1 with din_valid=0: slot <= 0, no capture.
- frame_start=1 while slot != 0 (aborted frame):
  - frame_err pulses 1 cycle.
  - Data and valid bits already captured in the aborted frame are retained.
  - No frame_done for the aborted frame.
- frame_start=1 while slot == 0: normal, no error.
- Overrun: capture into channel n while ch_valid[n]=1 and rd_ack[n]=0 sets overrun[n]. overrun is sticky until ovr_clr or reset.
- rd_ack[n]=1 clears ch_valid[n] next cycle. If rd_ack[n] coincides with a capture into n, the capture wins: ch_valid[n] stays 1 and no overrun is flagged.
- ovr_clr coinciding with a new overrun event: the set wins.
- din_valid=0 and frame_start=0: all state holds; pulses return to 0.
- rd_ack on a channel with ch_valid=0: no effect.

Optional Feature:
TDM_PARITY_EN
- Defined:
  - Frame is NCH+1 slots. Slot NCH carries the even-parity word: bitwise XOR of the NCH data samples of this frame.
  - The parity sample is not stored and does not touch any ch_valid.
  - A running XOR is cleared at slot 0 (or frame_start) and accumulated on every data capture.
  - On the parity slot: match pulses frame_done; mismatch pulses parity_err instead of frame_done.
  - slot reaches NCH.
- Not defined:
  - Frame is NCH slots, no accumulator logic, parity_err tied 0.

Test Plan:
- Reset 1 held 11 ns, then din_valid bursts din=1,0,1 with frame_start on the first beat. Expect: ch_data=3'b101, ch_valid=3'b111, frame_done pulse 1 cycle after third beat, slot=0.
- Two frames without rd_ack (1,1,0 then 0,1,1). Expect: overrun=3'b111, ch_data=3'b110 (bit n = channel n); ovr_clr -> overrun=0.
- Frame with rd_ack[1]=1 on the same cycle channel 1 is written. Expect: ch_valid[1]=1, overrun[1]=0; rd_ack[1] next cycle -> ch_valid[1]=0.
- Two beats, then frame_start with din=1. Expect: frame_err pulse, sample lands in ch0, slot=1, no frame_done.
- Assert reset mid-frame (slot=2). Expect: all outputs 0 immediately, without waiting for clk; next frame captures from slot 0.
- With TDM_PARITY_EN: data 1,0,1 then parity 0 -> frame_done; data 1,0,1 then parity 1 -> parity_err, no frame_done, ch_valid=3'b111.
